c_enc: RTL and testbench
========================

Name: c_enc

Overview:
- Streaming binary-to-unary (thermometer) encoder; the producer side of the unary code checked by the c-family validity logic.
- Accepts a binary count N over a valid/ready handshake and emits a P_W-bit unary vector: bit 0 is the first position, and bits [N-1:0] are set.
- Two-stage registered pipeline with full backpressure and one word per cycle throughput.
- Boundary counts are flagged explicitly: all-clear (N=0), all-set (N=P_W) and out-of-range (N>P_W).

Parameters:
- P_W, 8, output vector width; must be >= 2.
- P_NW, 8, input count width; must satisfy 2**P_NW > P_W.
- P_IS_COMPLIMENT, 0, when 1 every output bit is inverted: first bit 0, terminal value 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input count valid.
- i_n  input  P_NW  binary count N.
- o_ready  output  1  encoder can accept i_n this cycle.
- o_valid  output  1  output word valid.
- o_x  output  P_W  unary vector.
- o_kind  output  2  0=proper unary (1<=N<=P_W-1), 1=all-clear (N=0), 2=all-set (N=P_W), 3=range error (N>P_W).
- i_ready  input  1  downstream accepts the output word.

Behaviour:
- Reset: all stage-valid flags = 0. o_valid=0, o_x=0, o_kind=0; these hold for the reset cycle and the cycle after. o_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight words; no partial output appears afterwards.
- Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
- Stage 1 (S1) registers N and the classification:
  - eq0 = (N==0)
  - full = (N==P_W)
  - err = (N>P_W)
  - Comparisons are zero-extended to max(P_NW, $clog2(P_W+1)) bits.
- Stage 2 (S2) registers the vector and o_kind:
  - Non-complement: bit i = (i < N) for i in [0,P_W-1].
  - err forces the vector to all-ones and o_kind=3.
  - P_IS_COMPLIMENT=1: the vector is bitwise inverted after the err override; o_kind is unchanged.
- Advance rules:
  - s2_adv = ~s2_valid | i_ready
  - s1_adv = ~s1_valid | s2_adv
  - o_ready = s1_adv (combinational, no dependency on i_valid).
- Latency: an input accepted in cycle t is presented on o_valid in cycle t+2 when there is no stall.
- Throughput: 1 word/cycle with i_ready held at 1; no bubbles are inserted.
- Stall: with i_ready=0, S2 holds o_x/o_kind stable while o_valid=1. S1 fills and o_ready then drops. At most 2 words are in flight.
- Simultaneous accept and emit in the same cycle is legal and must lose no word.
- o_x and o_kind must not change while o_valid=1 and i_ready=0.
- i_n is sampled only on an input transfer; i_n is don't-care otherwise.

Optional Feature:
- Macro: C_ENC_STATS_EN.
- When defined, add outputs:
  - o_stat_words, 32 bits: output transfers.
  - o_stat_err, 32 bits: output transfers with o_kind=3.
- Both counters saturate at 2**32-1, reset to 0 on rst, and update the cycle after the transfer.
- When undefined, these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- P_W=8, P_IS_COMPLIMENT=0, i_ready=1, send N=3 in cycle t -> o_valid in cycle t+2, o_x=8'b0000_0111, o_kind=0.
- P_IS_COMPLIMENT=1, N=3 -> o_x=8'b1111_1000, o_kind=0. N=1 -> o_x=8'b1111_1110, o_kind=0.
- Boundaries, P_W=8:
  - N=0 -> o_x=8'h00, o_kind=1.
  - N=8 -> o_x=8'hFF, o_kind=2.
  - N=200 -> o_x=8'hFF, o_kind=3.
  - N=7 -> o_x=8'h7F, o_kind=0.
- Back-to-back N=1..7 with i_ready=1 -> 7 consecutive output cycles with o_x=2**N-1; o_ready never drops.
- Backpressure:
  - i_ready=0 for 5 cycles while i_valid=1 with N=2,4,6,... -> exactly 2 words accepted, o_ready=0 thereafter, o_x=8'h03 stable.
  - Release i_ready -> outputs 8'h03, 8'h0F, 8'h3F in order with no loss or duplication.
- Assert rst for 1 cycle with 2 words in flight -> o_valid=0 for the next 2 cycles. The next accepted N=5 yields o_x=8'h1F. With C_ENC_STATS_EN defined, counters read 0 after reset and o_stat_err increments only on kind=3 outputs.

Source files
------------

// File: rtl/c_enc_if.sv
// c_enc stream interface: count in, unary word out.
// Both directions use a valid/ready handshake.
interface c_enc_if #(
  parameter int P_W  = 8,
  parameter int P_NW = 8
);
  logic            i_valid;
  logic [P_NW-1:0] i_n;
  logic            o_ready;
  logic            o_valid;
  logic [P_W-1:0]  o_x;
  logic [1:0]      o_kind;
  logic            i_ready;

  modport slave (
    input  i_valid, i_n, i_ready,
    output o_ready, o_valid, o_x, o_kind
  );

  modport master (
    output i_valid, i_n, i_ready,
    input  o_ready, o_valid, o_x, o_kind
  );
endinterface

// File: rtl/c_enc.sv
// c_enc: two-stage binary-to-thermometer encoder.
// Optional C_ENC_STATS_EN adds transfer/error counters.
module c_enc #(
  parameter int P_W             = 8,
  parameter int P_NW            = 8,
  parameter int P_IS_COMPLIMENT = 0
) (
  input  logic        clk,
  input  logic        rst,
  c_enc_if.slave      bus
`ifdef C_ENC_STATS_EN
  ,
  output logic [31:0] o_stat_words,
  output logic [31:0] o_stat_err
`endif
);

  localparam int CW_R = $clog2(P_W + 1);
  localparam int CW   = (P_NW > CW_R) ? P_NW : CW_R;

  logic            s1_valid_q, s1_valid_d;
  logic [P_NW-1:0] s1_n_q, s1_n_d;
  logic            s1_eq0_q, s1_eq0_d;
  logic            s1_full_q, s1_full_d;
  logic            s1_err_q, s1_err_d;

  logic            s2_valid_q, s2_valid_d;
  logic [P_W-1:0]  s2_x_q, s2_x_d;
  logic [1:0]      s2_kind_q, s2_kind_d;

  logic            s1_adv, s2_adv, in_xfer;
  logic [CW-1:0]   n_in, n_s1, w_ext;
  logic [P_W-1:0]  vec;
  logic [1:0]      kind;

  assign s2_adv  = ~s2_valid_q | bus.i_ready;
  assign s1_adv  = ~s1_valid_q | s2_adv;
  assign in_xfer = bus.i_valid & s1_adv;

  assign n_in  = CW'(bus.i_n);
  assign n_s1  = CW'(s1_n_q);
  assign w_ext = CW'(P_W);

  assign bus.o_ready = s1_adv;
  assign bus.o_valid = s2_valid_q;
  assign bus.o_x     = s2_x_q;
  assign bus.o_kind  = s2_kind_q;

  // Unary vector and kind from the stage-1 count.
  always_comb begin
    vec = '0;
    for (int i = 0; i < P_W; i++) begin
      vec[i] = (CW'(i) < n_s1);
    end
    if (s1_err_q) vec = '1;
    if (P_IS_COMPLIMENT != 0) vec = ~vec;
    kind = 2'd0;
    if (s1_err_q)       kind = 2'd3;
    else if (s1_full_q) kind = 2'd2;
    else if (s1_eq0_q)  kind = 2'd1;
  end

  // Next state for both stages under backpressure.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_n_d     = s1_n_q;
    s1_eq0_d   = s1_eq0_q;
    s1_full_d  = s1_full_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_kind_d  = s2_kind_q;
    if (s1_adv) s1_valid_d = bus.i_valid;
    if (in_xfer) begin
      s1_n_d    = bus.i_n;
      s1_eq0_d  = (n_in == '0);
      s1_full_d = (n_in == w_ext);
      s1_err_d  = (n_in > w_ext);
    end
    if (s2_adv) s2_valid_d = s1_valid_q;
    if (s2_adv && s1_valid_q) begin
      s2_x_d    = vec;
      s2_kind_d = kind;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_n_q     <= '0;
      s1_eq0_q   <= 1'b0;
      s1_full_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_kind_q  <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_n_q     <= s1_n_d;
      s1_eq0_q   <= s1_eq0_d;
      s1_full_q  <= s1_full_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_kind_q  <= s2_kind_d;
    end
  end

`ifdef C_ENC_STATS_EN
  logic        out_xfer;
  logic [31:0] words_q, words_d;
  logic [31:0] err_q, err_d;

  assign out_xfer     = s2_valid_q & bus.i_ready;
  assign o_stat_words = words_q;
  assign o_stat_err   = err_q;

  // Saturating counters of output transfers.
  always_comb begin
    words_d = words_q;
    err_d   = err_q;
    if (out_xfer && (words_q != '1)) words_d = words_q + 32'd1;
    if (out_xfer && (s2_kind_q == 2'd3) && (err_q != '1))
      err_d = err_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      err_q   <= '0;
    end else begin
      words_q <= words_d;
      err_q   <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_c_enc.sv
// Directed bench for c_enc (plain and complement).
// Build with C_ENC_STATS_EN to also check counters.
module tb_c_enc;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc;

  always #5 clk = ~clk;

  c_enc_if #(.P_W(8), .P_NW(8)) if0 ();
  c_enc_if #(.P_W(8), .P_NW(8)) if1 ();

  assign if1.i_valid = if0.i_valid;
  assign if1.i_n     = if0.i_n;
  assign if1.i_ready = if0.i_ready;

`ifdef C_ENC_STATS_EN
  logic [31:0] sw0, se0, sw1, se1;
`endif

  c_enc #(.P_W(8), .P_NW(8), .P_IS_COMPLIMENT(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(if0)
`ifdef C_ENC_STATS_EN
    , .o_stat_words(sw0), .o_stat_err(se0)
`endif
  );

  c_enc #(.P_W(8), .P_NW(8), .P_IS_COMPLIMENT(1)) dutc (
    .clk(clk),
    .rst(rst),
    .bus(if1)
`ifdef C_ENC_STATS_EN
    , .o_stat_words(sw1), .o_stat_err(se1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic single(input logic [7:0] n, input logic [7:0] x,
                        input logic [1:0] k, input logic [7:0] xc);
    if0.i_valid = 1'b1;
    if0.i_n     = n;
    step();
    if0.i_valid = 1'b0;
    chk($sformatf("lat1_n%0d", n), {31'd0, if0.o_valid}, 32'd0);
    step();
    chk($sformatf("vld_n%0d", n), {31'd0, if0.o_valid}, 32'd1);
    chk($sformatf("x_n%0d", n), {24'd0, if0.o_x}, {24'd0, x});
    chk($sformatf("kind_n%0d", n), {30'd0, if0.o_kind}, {30'd0, k});
    chk($sformatf("xc_n%0d", n), {24'd0, if1.o_x}, {24'd0, xc});
    chk($sformatf("kc_n%0d", n), {30'd0, if1.o_kind}, {30'd0, k});
  endtask

  initial begin
    rst         = 1'b1;
    if0.i_valid = 1'b0;
    if0.i_n     = '0;
    if0.i_ready = 1'b1;
    step();
    chk("rst_vld", {31'd0, if0.o_valid}, 32'd0);
    chk("rst_x", {24'd0, if0.o_x}, 32'd0);
    chk("rst_kind", {30'd0, if0.o_kind}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_vld", {31'd0, if0.o_valid}, 32'd0);
    chk("post_rst_rdy", {31'd0, if0.o_ready}, 32'd1);

    single(8'd3,   8'h07, 2'd0, 8'hF8);
    single(8'd0,   8'h00, 2'd1, 8'hFF);
    single(8'd8,   8'hFF, 2'd2, 8'h00);
    single(8'd200, 8'hFF, 2'd3, 8'h00);
    single(8'd7,   8'h7F, 2'd0, 8'h80);
    single(8'd1,   8'h01, 2'd0, 8'hFE);
    step();
    chk("drain_vld", {31'd0, if0.o_valid}, 32'd0);
`ifdef C_ENC_STATS_EN
    chk("stat_words6", sw0, 32'd6);
    chk("stat_err1", se0, 32'd1);
`endif

    for (int c = 0; c < 9; c++) begin
      if0.i_valid = (c < 7);
      if0.i_n     = 8'(c + 1);
      #1;
      chk($sformatf("b2b_rdy%0d", c), {31'd0, if0.o_ready}, 32'd1);
      step();
      if (c >= 1 && c <= 7) begin
        chk($sformatf("b2b_vld%0d", c), {31'd0, if0.o_valid}, 32'd1);
        chk($sformatf("b2b_x%0d", c), {24'd0, if0.o_x},
            (32'd1 << c) - 32'd1);
      end
    end
    chk("b2b_end_vld", {31'd0, if0.o_valid}, 32'd0);

    if0.i_ready = 1'b0;
    if0.i_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      if0.i_n = 8'((acc + 1) * 2);
      #1;
      if (if0.o_ready) acc++;
      step();
      if (c >= 1) begin
        chk($sformatf("bp_vld%0d", c), {31'd0, if0.o_valid}, 32'd1);
        chk($sformatf("bp_x%0d", c), {24'd0, if0.o_x}, 32'h03);
        #1;
        chk($sformatf("bp_rdy%0d", c), {31'd0, if0.o_ready}, 32'd0);
      end
    end
    chk("bp_accepted", acc, 32'd2);
    if0.i_n     = 8'((acc + 1) * 2);
    if0.i_ready = 1'b1;
    #1;
    chk("rel_rdy", {31'd0, if0.o_ready}, 32'd1);
    chk("rel_x0", {24'd0, if0.o_x}, 32'h03);
    step();
    if0.i_valid = 1'b0;
    chk("rel_vld1", {31'd0, if0.o_valid}, 32'd1);
    chk("rel_x1", {24'd0, if0.o_x}, 32'h0F);
    step();
    chk("rel_vld2", {31'd0, if0.o_valid}, 32'd1);
    chk("rel_x2", {24'd0, if0.o_x}, 32'h3F);
    step();
    chk("rel_end_vld", {31'd0, if0.o_valid}, 32'd0);
`ifdef C_ENC_STATS_EN
    chk("stat_words16", sw0, 32'd16);
    chk("stat_err_still1", se0, 32'd1);
`endif

    if0.i_ready = 1'b0;
    if0.i_valid = 1'b1;
    if0.i_n     = 8'd3;
    step();
    if0.i_n = 8'd4;
    step();
    if0.i_valid = 1'b0;
    chk("inflight_vld", {31'd0, if0.o_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_vld0", {31'd0, if0.o_valid}, 32'd0);
    chk("mid_rst_x0", {24'd0, if0.o_x}, 32'd0);
`ifdef C_ENC_STATS_EN
    chk("stat_words_rst", sw0, 32'd0);
    chk("stat_err_rst", se0, 32'd0);
`endif
    step();
    chk("mid_rst_vld1", {31'd0, if0.o_valid}, 32'd0);
    if0.i_ready = 1'b1;
    if0.i_valid = 1'b1;
    if0.i_n     = 8'd5;
    step();
    if0.i_valid = 1'b0;
    chk("n5_lat1", {31'd0, if0.o_valid}, 32'd0);
    step();
    chk("n5_vld", {31'd0, if0.o_valid}, 32'd1);
    chk("n5_x", {24'd0, if0.o_x}, 32'h1F);
    step();
    chk("n5_end_vld", {31'd0, if0.o_valid}, 32'd0);
`ifdef C_ENC_STATS_EN
    chk("stat_words_n5", sw0, 32'd1);
    chk("stat_err_n5", se0, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
